predictor_ghist_param: RTL

- Parametrised two-level global-history branch predictor; successor to the fixed 2-bit-history / 4-bank / 2-bit-counter predictor.
- Generalises history length, counter width and table depth, with a selectable index hash: gselect (concatenation) or gshare (XOR).
- Adds a table-initialisation / flush state machine, so the counter array needs no per-flop reset.
- Sits beside fetch: read side is indexed by next_pc; update side is driven by resolved branches from EX.

---
 rtl/predictor_ghist_param.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/predictor_ghist_param.sv
// Two-level global-history branch predictor with a selectable index hash.
// The counter table is swept to weakly-not-taken by an INIT state after reset
// or flush, so the array itself carries no reset and can map onto plain RAM.
module predictor_ghist_param #(
  parameter int ADDR_WIDTH    = 32,
  parameter int ENTRY_NUM     = 256,
  parameter int PR_ADDR_WIDTH = $clog2(ENTRY_NUM),
  parameter int GHR_WIDTH     = 4,
  parameter int CNT_WIDTH     = 2,
  parameter int INDEX_MODE    = 1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic                  branch_ex,
  input  logic                  is_loop_ex,
  input  logic                  branch_taken_ex,
  input  logic [ADDR_WIDTH-1:0] branch_pc_ex,
  input  logic                  flush_req,
  output logic [CNT_WIDTH-1:0]  predictor,
  output logic                  predict_taken,
  output logic                  predictor_ready
);

  localparam logic [CNT_WIDTH-1:0]     CNT_WNT  = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [PR_ADDR_WIDTH-1:0] LAST_IDX = PR_ADDR_WIDTH'(ENTRY_NUM - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   state_q, state_d;
  logic [PR_ADDR_WIDTH-1:0] init_idx_q, init_idx_d;
  logic [GHR_WIDTH-1:0]     ghr_q, ghr_d;

  logic [CNT_WIDTH-1:0]     cnt_table [ENTRY_NUM];

  logic [PR_ADDR_WIDTH-1:0] rd_pc_idx, wr_pc_idx;
  logic [PR_ADDR_WIDTH-1:0] rd_idx, wr_idx;
  logic                     upd;
  logic                     tbl_we;
  logic [PR_ADDR_WIDTH-1:0] tbl_waddr;
  logic [CNT_WIDTH-1:0]     tbl_wdata;
  logic [CNT_WIDTH-1:0]     cur_cnt;
  logic                     unused_ok;

  // Word-aligned PCs: drop the two byte-offset bits before indexing.
  assign rd_pc_idx = next_pc[PR_ADDR_WIDTH+1:2];
  assign wr_pc_idx = branch_pc_ex[PR_ADDR_WIDTH+1:2];

  // Upper PC bits (and, in some configurations, parts of pc_idx) do not feed the index.
  assign unused_ok = ^{next_pc, branch_pc_ex, rd_pc_idx, wr_pc_idx};

  // Index hash: both ports see the same pre-update history.
  generate
    if (INDEX_MODE == 0) begin : g_gselect
      if (GHR_WIDTH == PR_ADDR_WIDTH) begin : g_ghr_only
        assign rd_idx = ghr_q;
        assign wr_idx = ghr_q;
      end else begin : g_concat
        assign rd_idx = {ghr_q, rd_pc_idx[PR_ADDR_WIDTH-GHR_WIDTH-1:0]};
        assign wr_idx = {ghr_q, wr_pc_idx[PR_ADDR_WIDTH-GHR_WIDTH-1:0]};
      end
    end else begin : g_gshare
      assign rd_idx = rd_pc_idx ^ PR_ADDR_WIDTH'(ghr_q);
      assign wr_idx = wr_pc_idx ^ PR_ADDR_WIDTH'(ghr_q);
    end
  endgenerate

  // A flush in the same cycle wins over any resolved branch.
  assign upd = (state_q == ST_RUN) && branch_ex && !is_loop_ex && !flush_req;

  // Table write port: INIT sweep or saturating counter update.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = init_idx_q;
    tbl_wdata = CNT_WNT;
    cur_cnt   = cnt_table[wr_idx];
    if (state_q == ST_INIT) begin
      tbl_we = 1'b1;
    end else if (upd) begin
      tbl_we    = 1'b1;
      tbl_waddr = wr_idx;
      if (branch_taken_ex) begin
        tbl_wdata = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + CNT_WIDTH'(1);
      end else begin
        tbl_wdata = (cur_cnt == '0) ? cur_cnt : cur_cnt - CNT_WIDTH'(1);
      end
    end
  end

  // Counter array storage, deliberately without reset.
  always_ff @(posedge cpu_clk) begin
    if (tbl_we) begin
      cnt_table[tbl_waddr] <= tbl_wdata;
    end
  end

  // Next-state logic for the init/run FSM and the global history.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ghr_d      = ghr_q;
    if (flush_req) begin
      state_d    = ST_INIT;
      init_idx_d = '0;
      ghr_d      = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_idx_d = init_idx_q + PR_ADDR_WIDTH'(1);
          if (init_idx_q == LAST_IDX) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (upd) begin
            ghr_d = (ghr_q << 1) | GHR_WIDTH'(branch_taken_ex);
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // State, sweep pointer and history registers.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
    end
  end

  // Read port: zero-latency lookup, forced to weakly-not-taken until the table is valid.
  always_comb begin
    predictor_ready = (state_q == ST_RUN);
    predictor       = CNT_WNT;
    if (state_q == ST_RUN) begin
      predictor = cnt_table[rd_idx];
    end
    predict_taken = predictor[CNT_WIDTH-1];
  end

endmodule
